md_unit_ctrl: RTL and testbench
===============================

# md_unit_ctrl

Multi-cycle multiply/divide controller for the five-stage pipeline. Accepts mult/multu/div/divu/mthi/mtlo from the E stage, sequences a fixed-latency busy period, and owns the HI/LO registers. Generates the decode-stage stall that deasserts the D/E pipeline register enable while an HI/LO-dependent instruction in D must wait. Serves mfhi/mflo reads to the E stage.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15)

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- instr_D  in  32  instruction currently in D stage
- instr_E  in  32  instruction currently in E stage (E never stalls)
- rs_E  in  32  forwarded rs operand in E
- rt_E  in  32  forwarded rt operand in E
- stall_D  out  1  1 = freeze F/D, D/E enable low, bubble into E
- busy  out  1  1 = multiply/divide in progress
- hi  out  32  HI register
- lo  out  32  LO register
- md_out  out  32  mfhi/mflo result for E stage

## Operation
- Decode (opcode 000000, funct): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. "MD class" = any of these eight.
- States: IDLE, MUL, DIV; 4-bit counter cnt.
- IDLE, instr_E = mult/multu: latch rs_E, rt_E, signedness; cnt <= MULT_CYCLES; -> MUL.
- IDLE, instr_E = div/divu: same latching; cnt <= DIV_CYCLES; -> DIV.
- IDLE, instr_E = mthi: hi <= rs_E. mtlo: lo <= rs_E. State unchanged.
- MUL/DIV, cnt > 1: cnt <= cnt - 1.
- MUL/DIV, cnt = 1: write result, -> IDLE.
- MUL result: {hi,lo} <= 64-bit product; mult signed (two's complement), multu unsigned.
- DIV result: lo <= quotient, hi <= remainder. Signed: quotient truncates toward zero, remainder takes dividend's sign. 0x80000000 / 0xFFFFFFFF signed: lo = 0x80000000, hi = 0.
- Divisor = 0: full DIV_CYCLES busy period, hi/lo unchanged.
- MD-class instruction in E while busy: ignored (stall_D prevents this; no restart, no hi/lo write).
- busy = (state != IDLE).
- start_E = (state = IDLE) and instr_E ∈ {mult, multu, div, divu}.
- stall_D = instr_D is MD class and (busy or start_E). Combinational.
- md_out = hi if instr_E = mfhi, lo if instr_E = mflo, else 0. Combinational from registers.
- instr_D = 0 (nop) never stalls.

## Timing
- Reset (async, reset = 0): state IDLE, cnt = 0, hi = lo = 0, busy = 0. stall_D and md_out then follow their combinational definitions (0 unless instr_D/instr_E demand otherwise). Reset mid-operation aborts the operation; no result is written.
- Start edge T (mult in E, IDLE): busy = 1 for exactly N cycles after T (N = MULT_CYCLES or DIV_CYCLES). hi/lo are updated at the edge that ends the Nth busy cycle. busy = 0 and new hi/lo are visible in the same following cycle.
- stall_D is high in the cycle containing edge T (start_E) and during all N busy cycles. A waiting mfhi enters E at the first edge after busy falls and reads the new value.
- mthi/mtlo write at the edge where they occupy E. A mfhi in the immediately following E cycle reads the new value (no bypass needed).
- Back-to-back mult in D behind mult in E: stalled N+1 cycles, then starts at the first edge after busy falls.

## Test plan
- Reset: drive reset = 0 mid-MUL (cnt = 3) -> busy = 0, hi = lo = 0 immediately; no write after release.
- multu 0xFFFFFFFF × 0xFFFFFFFF, MULT_CYCLES = 5 -> busy high 5 cycles; then hi = 0xFFFFFFFE, lo = 0x00000001.
- mult −3 × 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. div −7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF (10 busy cycles).
- div by 0 with hi = 0x11, lo = 0x22 -> busy 10 cycles, then hi = 0x11, lo = 0x22. Signed 0x80000000 / −1 -> lo = 0x80000000, hi = 0.
- mult in E, mflo in D -> stall_D = 1 for 6 consecutive cycles; mflo then enters E and md_out = product low word. An addu in D in the same situation -> stall_D = 0.
- mthi 0xDEADBEEF in E, mfhi next in E -> md_out = 0xDEADBEEF, stall_D = 0 throughout.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer with HI/LO ownership and decode stall
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_d_i,
    input  logic [31:0] instr_e_i,
    input  logic [31:0] rs_e_i,
    input  logic [31:0] rt_e_i,
    output logic        stall_d_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] md_out_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        sgn_q, sgn_d;

    logic        rtype_e, rtype_d, md_d, start_e, mthi_e, mtlo_e, mfhi_e, mflo_e;
    logic [5:0]  fn_e, fn_d;
    logic [63:0] ax, bx, prod;
    logic        sa, sb;
    logic [31:0] ma, mb, dvs, qm, rm, quo, rem;

    // Decode of the D and E instructions; funct 0100xx and 0110xx cover the eight MD-class ops
    always_comb begin
        rtype_e  = instr_e_i[31:26] == 6'd0;
        rtype_d  = instr_d_i[31:26] == 6'd0;
        fn_e     = instr_e_i[5:0];
        fn_d     = instr_d_i[5:0];
        md_d     = rtype_d && (fn_d[5:2] == 4'b0100 || fn_d[5:2] == 4'b0110);
        start_e  = state_q == IDLE && rtype_e && fn_e[5:2] == 4'b0110;
        mfhi_e   = rtype_e && fn_e == 6'b010000;
        mthi_e   = rtype_e && fn_e == 6'b010001;
        mflo_e   = rtype_e && fn_e == 6'b010010;
        mtlo_e   = rtype_e && fn_e == 6'b010011;
        busy_o   = state_q != IDLE;
        stall_d_o = md_d && (busy_o || start_e);
        md_out_o = mfhi_e ? hi_q : mflo_e ? lo_q : 32'd0;
        hi_o     = hi_q;
        lo_o     = lo_q;
    end

    // Result datapath on latched operands; sign handled via magnitudes so INT_MIN / -1 wraps cleanly
    always_comb begin
        ax   = {{32{sgn_q & a_q[31]}}, a_q};
        bx   = {{32{sgn_q & b_q[31]}}, b_q};
        prod = ax * bx;
        sa   = sgn_q & a_q[31];
        sb   = sgn_q & b_q[31];
        ma   = sa ? -a_q : a_q;
        mb   = sb ? -b_q : b_q;
        dvs  = (mb == 32'd0) ? 32'd1 : mb;
        qm   = ma / dvs;
        rm   = ma % dvs;
        quo  = (sa ^ sb) ? -qm : qm;
        rem  = sa ? -rm : rm;
    end

    // Next-state: start/mthi/mtlo in IDLE, count down while busy, commit result on the last busy cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (start_e) begin
                a_d     = rs_e_i;
                b_d     = rt_e_i;
                sgn_d   = ~fn_e[0];
                cnt_d   = fn_e[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                state_d = fn_e[1] ? DIV : MUL;
            end else if (mthi_e) begin
                hi_d = rs_e_i;
            end else if (mtlo_e) begin
                lo_d = rs_e_i;
            end
        end else if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            state_d = IDLE;
            if (state_q == MUL) begin
                hi_d = prod[63:32];
                lo_d = prod[31:0];
            end else if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quo;
            end
        end
    end

    // State and HI/LO registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed self-checking bench for md_unit_ctrl
module tb_md_unit_ctrl;
    localparam logic [31:0] MULT  = 32'h18, MULTU = 32'h19, DIV = 32'h1a, DIVU = 32'h1b;
    localparam logic [31:0] MFHI  = 32'h10, MTHI  = 32'h11, MFLO = 32'h12, MTLO = 32'h13;
    localparam logic [31:0] ADDU  = 32'h21;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instr_d = '0, instr_e = '0, rs_e = '0, rt_e = '0;
    logic        stall_d, busy;
    logic [31:0] hi, lo, md_out;
    int          checks = 0, errors = 0;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk_i(clk), .rst_ni(rst_n), .instr_d_i(instr_d), .instr_e_i(instr_e),
        .rs_e_i(rs_e), .rt_e_i(rt_e), .stall_d_o(stall_d), .busy_o(busy),
        .hi_o(hi), .lo_o(lo), .md_out_o(md_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic run_op(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        instr_e = op; rs_e = a; rt_e = b;
        tick();
        instr_e = '0;
        #1;
        wait_idle(n);
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        instr_e = MTHI; rs_e = h;
        tick();
        instr_e = MTLO; rs_e = l;
        tick();
        instr_e = '0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_d !== 1'b0 || md_out !== 32'd0) begin
            errors++; $display("FAIL reset_init busy=%b hi=%h lo=%h stall=%b md=%h want 0", busy, hi, lo, stall_d, md_out);
        end
        rst_n = 1'b1;
        tick();
        write_hilo(32'h55, 32'h66);
        instr_e = MULTU; rs_e = 3; rt_e = 4;
        tick();
        instr_e = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_nowrite busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
    endtask

    task automatic test_mul();
        int n;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        checks++;
        if (n !== 5 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++; $display("FAIL multu busy=%0d hi=%h lo=%h want 5 fffffffe 00000001", n, hi, lo);
        end
        run_op(MULT, 32'hFFFFFFFD, 32'd7, n);
        checks++;
        if (n !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL mult busy=%0d hi=%h lo=%h want 5 ffffffff ffffffeb", n, hi, lo);
        end
    endtask

    task automatic test_div();
        int n;
        run_op(DIV, 32'hFFFFFFF9, 32'd2, n);
        checks++;
        if (n !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_neg busy=%0d hi=%h lo=%h want 10 ffffffff fffffffd", n, hi, lo);
        end
        run_op(DIVU, 32'hFFFFFFFF, 32'h10, n);
        checks++;
        if (n !== 10 || hi !== 32'h0000000F || lo !== 32'h0FFFFFFF) begin
            errors++; $display("FAIL divu busy=%0d hi=%h lo=%h want 10 0000000f 0fffffff", n, hi, lo);
        end
        write_hilo(32'h11, 32'h22);
        run_op(DIV, 32'd5, 32'd0, n);
        checks++;
        if (n !== 10 || hi !== 32'h11 || lo !== 32'h22) begin
            errors++; $display("FAIL div_zero busy=%0d hi=%h lo=%h want 10 00000011 00000022", n, hi, lo);
        end
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, n);
        checks++;
        if (n !== 10 || hi !== 32'd0 || lo !== 32'h80000000) begin
            errors++; $display("FAIL div_ovf busy=%0d hi=%h lo=%h want 10 00000000 80000000", n, hi, lo);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        instr_e = MULT; rs_e = 6; rt_e = 7; instr_d = MFLO;
        #1;
        if (stall_d) n++;
        tick();
        instr_e = '0;
        #1;
        while (stall_d && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL stall_mflo cycles=%0d want 6", n);
        end
        instr_e = MFLO; instr_d = '0;
        #1;
        checks++;
        if (md_out !== 32'd42 || stall_d !== 1'b0) begin
            errors++; $display("FAIL mflo_read md_out=%h stall=%b want 0000002a 0", md_out, stall_d);
        end
        tick();
        n = 0;
        instr_e = MULT; rs_e = 2; rt_e = 2; instr_d = ADDU;
        #1;
        if (stall_d) n++;
        tick();
        instr_e = '0;
        #1;
        for (int i = 0; i < 7; i++) begin
            if (stall_d) n++;
            tick();
        end
        checks++;
        if (n !== 0 || lo !== 32'd4) begin
            errors++; $display("FAIL stall_addu stalls=%0d lo=%h want 0 00000004", n, lo);
        end
        instr_d = '0;
    endtask

    task automatic test_mthi_mfhi();
        int n = 0;
        instr_e = MTHI; rs_e = 32'hDEADBEEF; instr_d = MFHI;
        #1;
        if (stall_d) n++;
        tick();
        instr_e = MFHI; instr_d = '0;
        #1;
        if (stall_d) n++;
        checks++;
        if (md_out !== 32'hDEADBEEF || n !== 0) begin
            errors++; $display("FAIL mthi_mfhi md_out=%h stalls=%0d want deadbeef 0", md_out, n);
        end
        instr_e = ADDU;
        #1;
        checks++;
        if (md_out !== 32'd0) begin
            errors++; $display("FAIL md_out_other md_out=%h want 00000000", md_out);
        end
        tick();
        instr_e = '0;
    endtask

    task automatic test_back_to_back();
        int n = 0, b = 0;
        instr_e = MULT; rs_e = 2; rt_e = 3; instr_d = MULT;
        #1;
        if (stall_d) n++;
        tick();
        instr_e = MTLO; rs_e = 32'h99;
        #1;
        if (stall_d) n++;
        tick();
        instr_e = '0;
        #1;
        checks++;
        if (lo !== 32'd4) begin
            errors++; $display("FAIL busy_ignore lo=%h want 00000004", lo);
        end
        while (stall_d && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 6 || lo !== 32'd6) begin
            errors++; $display("FAIL b2b_stall cycles=%0d lo=%h want 6 00000006", n, lo);
        end
        instr_e = MULT; rs_e = 4; rt_e = 5; instr_d = '0;
        tick();
        instr_e = '0;
        #1;
        wait_idle(b);
        checks++;
        if (b !== 5 || hi !== 32'd0 || lo !== 32'd20) begin
            errors++; $display("FAIL b2b_second busy=%0d hi=%h lo=%h want 5 00000000 00000014", b, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_stall();
        test_mthi_mfhi();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
